fetch_unit: RTL and testbench
=============================

Name: fetch_unit

Overview:
- Instruction fetch stage placed directly upstream of the instruction decoder.
- Keeps the fetch PC and issues word requests to instruction memory over a req/ack handshake.
- Buffers returned words in a small prefetch queue.
- Presents one instruction at a time to the decoder as `instruction` qualified by `isactive`, and flushes on branch redirect.

Parameters:
- PC_RESET, 32'h0000_0000, fetch address after reset; bits [1:0] must be 0.
- DEPTH, 2, prefetch queue entries; legal range 2..8.

Ports:
- clk  input  1  single clock; all state updates on rising edge
- rst_n  input  1  reset, synchronous, active-low
- imem_req  output  1  memory request valid
- imem_addr  output  32  word-aligned fetch address
- imem_ack  input  1  memory response; transfer completes in any cycle with imem_req && imem_ack
- imem_rdata  input  32  instruction word, valid in the ack cycle
- branch_valid  input  1  redirect request from execute, one-cycle pulse
- branch_target  input  32  redirect address; bits [1:0] ignored and forced to 0
- dec_ready  input  1  decoder accepts the presented instruction this cycle
- instruction  output  32  queue head word to the decoder
- instr_pc  output  32  address of the queue head word
- isactive  output  1  queue head valid; the decoder may act on `instruction`

Behaviour:
- Reset: rst_n low at an edge sets the following, overriding all other events including an in-flight request:
  - imem_req=0, imem_addr=PC_RESET
  - instruction=0, instr_pc=0, isactive=0
  - queue count=0, state=IDLE
- All outputs are driven from registers. No combinational path from any input to any output.
- State machine:
  - IDLE: if count<DEPTH and no branch this cycle → REQ. Set imem_req=1 with imem_addr=fetch PC.
  - REQ: imem_req and imem_addr held stable until ack.
    - On ack without branch: push {imem_rdata, imem_addr} into the queue; fetch PC += 4, wrapping modulo 2^32.
    - After the push: if count after push < DEPTH, remain in REQ with the new address (back-to-back fetch, one word per cycle at zero wait). Otherwise → IDLE with imem_req=0.
  - DISCARD: entered when a branch arrives in REQ without ack in the same cycle.
    - imem_req and the old address stay held; a request is never withdrawn.
    - On ack the data is dropped; imem_addr = redirect PC, → REQ.
- Branch handling (branch_valid=1, highest priority after reset):
  - Queue flushed; count=0 and isactive=0 next cycle.
  - A pop in the same cycle is ignored.
  - Fetch PC = {branch_target[31:2],2'b00}.
  - In IDLE → REQ with the target address.
  - In REQ with ack the same cycle: data dropped, → REQ with the target address.
  - In REQ without ack → DISCARD.
  - In DISCARD: target updated (latest wins), stay in DISCARD.
- Queue:
  - FIFO, circular read/write pointers modulo DEPTH.
  - Pop on isactive && dec_ready.
  - Push and pop in the same cycle leave count unchanged.
  - Never pushes when full: requests launch only when count<DEPTH, and count cannot rise while a request waits.
  - Pop when empty is impossible, since isactive=0.
- Output latency:
  - The head word appears on `instruction`/`instr_pc` with isactive=1 the cycle after the ack that pushes it into an empty queue.
  - Otherwise it appears the cycle after the pop of the previous head.
  - instruction and instr_pc hold their value while isactive && !dec_ready.
- First request after reset: imem_req=1 on the first edge with rst_n high (IDLE→REQ).

Optional Feature:
- Macro: FETCH_PERF_EN.
- Defined: adds outputs perf_fetched (32) and perf_flushed (32).
  - perf_fetched increments on every push.
  - perf_flushed increments on every branch_valid cycle plus every discarded ack.
  - Both reset to 0 and wrap modulo 2^32.
- Undefined: the ports and counters do not exist; behaviour is otherwise identical.

Test Plan:
- Reset release with a zero-wait memory (ack tied 1) returning addr^32'hE000_0000, and dec_ready=1:
  - imem_addr sequence 0,4,8…
  - isactive rises 2 cycles after release.
  - instruction = 32'hE000_0000 then 32'hE000_0004 with instr_pc 0 then 4, one per cycle.
- dec_ready=0 with zero-wait memory:
  - Exactly DEPTH=2 words fetched, then imem_req=0.
  - instruction held at the PC 0 word.
  - Raising dec_ready resumes fetch at address 8.
- Memory with a 3-cycle ack delay, branch_valid with target 32'h0000_0103 pulsed during a wait:
  - The old address stays held until ack and its data is dropped.
  - Next imem_addr = 32'h100.
  - The first delivered instr_pc = 32'h100.
- Branch in the same cycle as ack and a decoder pop:
  - The acked word is never presented.
  - isactive=0 next cycle.
  - The next request address is the target.
- PC_RESET=32'hFFFF_FFFC: the second fetch address wraps to 32'h0000_0000.
- rst_n low while in DISCARD:
  - Next cycle imem_req=0, isactive=0, imem_addr=PC_RESET.
  - With FETCH_PERF_EN defined, both counters read 0.

Source files
------------

// File: rtl/fetch_unit.sv
// fetch_unit -- instruction fetch stage feeding the decoder.
//
// Keeps the fetch PC, issues word requests to instruction memory over a
// req/ack handshake, buffers returned words in a DEPTH-entry prefetch FIFO
// and presents the head word to the decoder. A branch redirect flushes the
// queue. A request that is already outstanding is never withdrawn: its data
// is dropped when it returns.
//
// Parameters:
//   PC_RESET  fetch address after reset (word aligned)
//   DEPTH     prefetch queue entries, 2..8
//
// Ports:
//   clk, rst_n          clock, synchronous active-low reset
//   imem_req/addr       memory request valid / word address (registered)
//   imem_ack/rdata      memory response, data valid in the ack cycle
//   branch_valid/target redirect pulse and target (bits [1:0] ignored)
//   dec_ready           decoder accepts the presented instruction
//   instruction/instr_pc/isactive  queue head word, its address, head valid
//
// Optional feature, macro FETCH_PERF_EN:
//   perf_fetched  count of words pushed into the queue
//   perf_flushed  count of branch cycles plus acks dropped while discarding
module fetch_unit #(
  parameter logic [31:0] PC_RESET = 32'h0000_0000,
  parameter int          DEPTH    = 2
) (
  input  logic        clk,
  input  logic        rst_n,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_ack,
  input  logic [31:0] imem_rdata,
  input  logic        branch_valid,
  input  logic [31:0] branch_target,
  input  logic        dec_ready,
  output logic [31:0] instruction,
  output logic [31:0] instr_pc,
  output logic        isactive
`ifdef FETCH_PERF_EN
  ,
  output logic [31:0] perf_fetched,
  output logic [31:0] perf_flushed
`endif
);

  localparam int PW = (DEPTH > 2) ? $clog2(DEPTH) : 1;
  localparam int CW = $clog2(DEPTH + 1);
  localparam logic [CW-1:0] DEPTH_C  = CW'(DEPTH);
  localparam logic [PW-1:0] PTR_LAST = PW'(DEPTH - 1);

  typedef enum logic [1:0] {IDLE, REQ, DISCARD} state_t;

  state_t        r_state, w_state_nxt;
  logic          r_imem_req, w_req_nxt;
  logic [31:0]   r_imem_addr, w_addr_nxt;
  logic [31:0]   r_pc, w_pc_nxt;
  logic [31:0]   r_q_data [DEPTH];
  logic [31:0]   r_q_pc   [DEPTH];
  logic [PW-1:0] r_wptr, r_rptr, w_rptr_nxt;
  logic [CW-1:0] r_count, w_count_pop, w_count_nxt;
  logic [31:0]   r_instr, r_instr_pc;
  logic          r_isactive;

  logic          w_ack, w_push, w_pop, w_fwd;
  logic [31:0]   w_target, w_head_data, w_head_pc;

  function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
    return (p == PTR_LAST) ? '0 : p + PW'(1);
  endfunction

  assign w_ack    = r_imem_req & imem_ack;
  assign w_target = {branch_target[31:2], 2'b00};
  // A branch wins over both queue operations in the same cycle.
  assign w_push   = (r_state == REQ) & w_ack & ~branch_valid;
  assign w_pop    = r_isactive & dec_ready & ~branch_valid;

  assign w_count_pop = r_count - CW'(w_pop);
  assign w_count_nxt = branch_valid ? '0 : w_count_pop + CW'(w_push);
  assign w_rptr_nxt  = w_pop ? ptr_inc(r_rptr) : r_rptr;

  // Word pushed into a queue that is (or becomes) empty this cycle is the
  // next head; bypass the storage so it shows up one cycle after the ack.
  assign w_fwd       = w_push & (w_count_pop == '0);
  assign w_head_data = w_fwd ? imem_rdata  : r_q_data[w_rptr_nxt];
  assign w_head_pc   = w_fwd ? r_imem_addr : r_q_pc[w_rptr_nxt];

  // ---------------- FSM: state register ----------------
  always_ff @(posedge clk) begin
    if (!rst_n) r_state <= IDLE;
    else        r_state <= w_state_nxt;
  end

  // ---------------- FSM: next state ----------------
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      IDLE:    if (branch_valid || r_count < DEPTH_C) w_state_nxt = REQ;
      REQ: begin
        if (branch_valid)                           w_state_nxt = w_ack ? REQ : DISCARD;
        else if (w_ack && w_count_nxt == DEPTH_C)   w_state_nxt = IDLE;
      end
      // An ack that coincides with a further redirect still retires the
      // stale request, so go straight on to the newest target.
      DISCARD: if (w_ack) w_state_nxt = REQ;
      default: w_state_nxt = IDLE;
    endcase
  end

  // ---------------- FSM: outputs (next register values) ----------------
  always_comb begin
    w_pc_nxt   = r_pc;
    w_req_nxt  = r_imem_req;
    w_addr_nxt = r_imem_addr;
    if (branch_valid)  w_pc_nxt = w_target;
    else if (w_push)   w_pc_nxt = r_imem_addr + 32'd4;
    case (w_state_nxt)
      IDLE:    w_req_nxt = 1'b0;
      REQ: begin
        w_req_nxt = 1'b1;
        // New address only when a request starts or the current one retires.
        if (r_state != REQ || w_ack) w_addr_nxt = w_pc_nxt;
      end
      DISCARD: w_req_nxt = 1'b1;
      default: w_req_nxt = 1'b0;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_imem_req  <= 1'b0;
      r_imem_addr <= PC_RESET;
      r_pc        <= PC_RESET;
    end else begin
      r_imem_req  <= w_req_nxt;
      r_imem_addr <= w_addr_nxt;
      r_pc        <= w_pc_nxt;
    end
  end

  // ---------------- prefetch queue ----------------
  always_ff @(posedge clk) begin
    if (w_push) begin
      r_q_data[r_wptr] <= imem_rdata;
      r_q_pc[r_wptr]   <= r_imem_addr;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_wptr  <= '0;
      r_rptr  <= '0;
      r_count <= '0;
    end else begin
      r_count <= w_count_nxt;
      if (branch_valid) begin
        r_wptr <= '0;
        r_rptr <= '0;
      end else begin
        if (w_push) r_wptr <= ptr_inc(r_wptr);
        r_rptr <= w_rptr_nxt;
      end
    end
  end

  // Decoder-facing head registers; hold while stalled or empty.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_isactive <= 1'b0;
      r_instr    <= '0;
      r_instr_pc <= '0;
    end else begin
      r_isactive <= (w_count_nxt != '0);
      if (w_count_nxt != '0) begin
        r_instr    <= w_head_data;
        r_instr_pc <= w_head_pc;
      end
    end
  end

  assign imem_req    = r_imem_req;
  assign imem_addr   = r_imem_addr;
  assign instruction = r_instr;
  assign instr_pc    = r_instr_pc;
  assign isactive    = r_isactive;

`ifdef FETCH_PERF_EN
  logic [31:0] r_perf_fetched, r_perf_flushed;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_perf_fetched <= '0;
      r_perf_flushed <= '0;
    end else begin
      r_perf_fetched <= r_perf_fetched + 32'(w_push);
      r_perf_flushed <= r_perf_flushed + 32'(branch_valid)
                        + 32'((r_state == DISCARD) && w_ack);
    end
  end

  assign perf_fetched = r_perf_fetched;
  assign perf_flushed = r_perf_flushed;
`endif

endmodule

// File: tb/tb_fetch_unit.sv
// Bench for fetch_unit: directed scenarios followed by random memory/branch/
// decoder traffic, all checked cycle by cycle against a queue-based model of
// the fetch stream. A second instance with PC_RESET=FFFF_FFFC checks wrap.
module tb_fetch_unit;
  localparam int          DEPTH = 2;
  localparam logic [31:0] XM    = 32'hE000_0000;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst_n, imem_ack, branch_valid, dec_ready;
  logic [31:0] branch_target;
  logic        imem_req, isactive;
  logic [31:0] imem_addr, imem_rdata, instruction, instr_pc;
  logic        w_req, w_act;
  logic [31:0] w_addr, w_rdata, w_instr, w_ipc;

  // Memory returns addr ^ E000_0000.
  assign imem_rdata = imem_addr ^ XM;
  assign w_rdata    = w_addr ^ XM;

`ifdef FETCH_PERF_EN
  logic [31:0] pf_f, pf_x, wpf_f, wpf_x;
`endif

  fetch_unit #(.PC_RESET(32'h0000_0000), .DEPTH(DEPTH)) dut (
    .clk(clk), .rst_n(rst_n),
    .imem_req(imem_req), .imem_addr(imem_addr),
    .imem_ack(imem_ack), .imem_rdata(imem_rdata),
    .branch_valid(branch_valid), .branch_target(branch_target),
    .dec_ready(dec_ready),
    .instruction(instruction), .instr_pc(instr_pc), .isactive(isactive)
`ifdef FETCH_PERF_EN
    , .perf_fetched(pf_f), .perf_flushed(pf_x)
`endif
  );

  fetch_unit #(.PC_RESET(32'hFFFF_FFFC), .DEPTH(DEPTH)) dut_w (
    .clk(clk), .rst_n(rst_n),
    .imem_req(w_req), .imem_addr(w_addr),
    .imem_ack(1'b1), .imem_rdata(w_rdata),
    .branch_valid(1'b0), .branch_target(32'h0),
    .dec_ready(1'b1),
    .instruction(w_instr), .instr_pc(w_ipc), .isactive(w_act)
`ifdef FETCH_PERF_EN
    , .perf_fetched(wpf_f), .perf_flushed(wpf_x)
`endif
  );

  int vecs = 0;
  int errs = 0;

  // Reference model: the prefetch queue is a plain SV queue of {word, pc}.
  bit          m_req, m_disc, m_rst;
  logic [31:0] m_addr, m_pc, m_instr, m_ipc, m_pf_f, m_pf_x;
  logic [63:0] mq[$];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vecs++;
    assert (obs === exp) else begin
      errs++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic model(input bit rst, input bit ack, input bit br,
                       input logic [31:0] tgt, input bit rdy);
    bit done, pop;
    int cnt0;
    m_rst = rst;
    if (rst) begin
      m_req = 0; m_disc = 0; m_addr = 32'h0; m_pc = 32'h0;
      m_instr = 0; m_ipc = 0; m_pf_f = 0; m_pf_x = 0;
      mq.delete();
      return;
    end
    done = m_req && ack;
    cnt0 = mq.size();
    pop  = (cnt0 > 0) && rdy;
    if (br)              m_pf_x++;
    if (m_disc && done)  m_pf_x++;
    if (br) begin
      mq.delete();
      m_pc = {tgt[31:2], 2'b00};
      if (!m_req)     begin m_req = 1; m_addr = m_pc; end
      else if (done)  begin m_disc = 0; m_addr = m_pc; end
      else            m_disc = 1;
    end else begin
      if (pop) void'(mq.pop_front());
      if (done) begin
        if (m_disc) begin
          m_disc = 0; m_addr = m_pc;
        end else begin
          mq.push_back({m_addr ^ XM, m_addr});
          m_pf_f++;
          m_pc = m_addr + 32'd4;
          if (mq.size() < DEPTH) m_addr = m_pc;
          else                   m_req = 0;
        end
      end else if (!m_req && cnt0 < DEPTH) begin
        m_req = 1; m_addr = m_pc;
      end
    end
    if (mq.size() > 0) begin
      m_instr = mq[0][63:32];
      m_ipc   = mq[0][31:0];
    end
  endtask

  task automatic check_all();
    chk("req",  {31'b0, imem_req}, {31'b0, m_req});
    chk("addr", imem_addr, m_addr);
    chk("isactive", {31'b0, isactive}, {31'b0, (mq.size() > 0)});
    if (mq.size() > 0 || m_rst) begin
      chk("instruction", instruction, m_instr);
      chk("instr_pc", instr_pc, m_ipc);
    end
`ifdef FETCH_PERF_EN
    chk("perf_fetched", pf_f, m_pf_f);
    chk("perf_flushed", pf_x, m_pf_x);
`endif
  endtask

  // One clock: drive at negedge, advance model, check at next negedge.
  task automatic cyc(input bit rst, input bit ack, input bit br,
                     input logic [31:0] tgt, input bit rdy);
    rst_n = !rst; imem_ack = ack; branch_valid = br;
    branch_target = tgt; dec_ready = rdy;
    model(rst, ack, br, tgt, rdy);
    @(posedge clk);
    @(negedge clk);
    check_all();
  endtask

  initial begin
    rst_n = 0; imem_ack = 0; branch_valid = 0; branch_target = 0; dec_ready = 0;
    @(negedge clk);

    // Reset state
    cyc(1, 0, 0, 0, 0);
    cyc(1, 1, 0, 0, 1);
    chk("rst_req", {31'b0, imem_req}, 32'd0);
    chk("rst_addr", imem_addr, 32'h0);
    chk("rst_wrap_addr", w_addr, 32'hFFFF_FFFC);

    // Zero-wait memory, decoder always ready
    cyc(0, 1, 0, 0, 1);
    chk("t1_addr0", imem_addr, 32'h0);
    chk("t1_act0", {31'b0, isactive}, 32'd0);
    chk("wrap_addr0", w_addr, 32'hFFFF_FFFC);
    cyc(0, 1, 0, 0, 1);
    chk("t1_act1", {31'b0, isactive}, 32'd1);
    chk("t1_instr0", instruction, 32'hE000_0000);
    chk("t1_pc0", instr_pc, 32'h0);
    chk("wrap_addr1", w_addr, 32'h0000_0000);
    cyc(0, 1, 0, 0, 1);
    chk("t1_instr1", instruction, 32'hE000_0004);
    chk("t1_pc1", instr_pc, 32'h4);
    chk("t1_addr2", imem_addr, 32'h8);

    // Decoder stalled: exactly DEPTH words, then request drops
    cyc(1, 0, 0, 0, 0);
    for (int i = 0; i < 5; i++) cyc(0, 1, 0, 0, 0);
    chk("t2_req_off", {31'b0, imem_req}, 32'd0);
    chk("t2_hold_pc", instr_pc, 32'h0);
    chk("t2_hold_instr", instruction, 32'hE000_0000);
    for (int i = 0; i < 10 && !imem_req; i++) cyc(0, 0, 0, 0, 1);
    chk("t2_resume_req", {31'b0, imem_req}, 32'd1);
    chk("t2_resume_addr", imem_addr, 32'h8);

    // 3-cycle ack delay, branch during the wait
    cyc(1, 0, 0, 0, 1);
    cyc(0, 0, 0, 0, 1);
    cyc(0, 0, 1, 32'h0000_0103, 1);
    chk("t3_hold_addr", imem_addr, 32'h0);
    chk("t3_hold_req", {31'b0, imem_req}, 32'd1);
    cyc(0, 0, 0, 0, 1);
    chk("t3_hold_addr2", imem_addr, 32'h0);
    cyc(0, 1, 0, 0, 1);
    chk("t3_dropped", {31'b0, isactive}, 32'd0);
    chk("t3_new_addr", imem_addr, 32'h100);
    cyc(0, 1, 0, 0, 1);
    chk("t3_first_pc", instr_pc, 32'h100);

    // Branch coinciding with ack and a decoder pop
    cyc(1, 0, 0, 0, 1);
    for (int i = 0; i < 3; i++) cyc(0, 1, 0, 0, 1);
    cyc(0, 1, 1, 32'h0000_0200, 1);
    chk("t4_flush", {31'b0, isactive}, 32'd0);
    chk("t4_addr", imem_addr, 32'h200);
    cyc(0, 1, 0, 0, 1);
    chk("t4_next_pc", instr_pc, 32'h200);

    // Reset while discarding
    cyc(1, 0, 0, 0, 1);
    cyc(0, 0, 0, 0, 1);
    cyc(0, 0, 1, 32'h40, 1);
    cyc(1, 0, 0, 0, 1);
    chk("t6_req", {31'b0, imem_req}, 32'd0);
    chk("t6_act", {31'b0, isactive}, 32'd0);
    chk("t6_addr", imem_addr, 32'h0);
`ifdef FETCH_PERF_EN
    chk("t6_pf_f", pf_f, 32'h0);
    chk("t6_pf_x", pf_x, 32'h0);
`endif

    // Random traffic
    for (int i = 0; i < 600; i++)
      cyc($urandom_range(0, 199) == 0, $urandom_range(0, 1) == 1,
          $urandom_range(0, 19) == 0, $urandom, $urandom_range(0, 9) < 6);

    $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
    $finish;
  end
endmodule
